// File: rtl/operand_sequencer_pkg.sv
// Shared definitions for the byte-serial operand sequencer: state encoding,
// default byte counts and counter-width helpers.
package operand_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_UNLOAD = 2'd3
  } seq_state_e;

  localparam int WAIT_CNT_W         = 4;
  localparam int DEF_LOG2_BYTES_IN  = 3;
  localparam int DEF_LOG2_BYTES_OUT = 2;
  localparam int BYTES_IN           = 1 << DEF_LOG2_BYTES_IN;
  localparam int BYTES_OUT          = 1 << DEF_LOG2_BYTES_OUT;

  function automatic int bytes_of(input int log2_bytes);
    return 1 << log2_bytes;
  endfunction

  // A single-byte stream still needs a one-bit counter to stay legal.
  function automatic int cnt_width(input int log2_bytes);
    return (log2_bytes > 0) ? log2_bytes : 1;
  endfunction

endpackage

// File: rtl/operand_sequencer_byte_unpacker.sv
// Result register plus byte-select mux; drives zero whenever the stream is idle.
module byte_unpacker
  import operand_sequencer_pkg::*;
#(
  parameter int LOG2_BYTES = 2
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                capture,
  input  logic [(1 << LOG2_BYTES)*8-1:0]      result_in,
  input  logic [cnt_width(LOG2_BYTES)-1:0]    sel,
  input  logic                                enable,
  output logic [7:0]                          byte_out
);

  localparam int NB    = bytes_of(LOG2_BYTES);
  localparam int CNT_W = cnt_width(LOG2_BYTES);

  logic [NB*8-1:0] result_q;
  logic [7:0]      sel_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
    end else if (capture) begin
      result_q <= result_in;
    end
  end

  always_comb begin
    sel_byte = '0;
    for (int i = 0; i < NB; i++) begin
      if (sel == CNT_W'(i)) begin
        sel_byte = result_q[i*8 +: 8];
      end
    end
    byte_out = enable ? sel_byte : 8'h00;
  end

endmodule

// File: rtl/operand_sequencer.sv
// Byte-serial sequencer for the shared test datapath: gathers operand bytes,
// pulses dp_start, waits a fixed latency, then streams the result bytes out.
module operand_sequencer
  import operand_sequencer_pkg::*;
#(
  parameter int LOG2_BYTES_IN  = 3,
  parameter int LOG2_BYTES_OUT = 2,
  parameter int LATENCY        = 1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   flush,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [7:0]                             in_data,
  output logic [(1 << LOG2_BYTES_IN)*8-1:0]      dp_operands,
  output logic                                   dp_start,
  input  logic [(1 << LOG2_BYTES_OUT)*8-1:0]     dp_result,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [7:0]                             out_data,
  output logic                                   busy
);

  localparam int NB_IN     = bytes_of(LOG2_BYTES_IN);
  localparam int NB_OUT    = bytes_of(LOG2_BYTES_OUT);
  localparam int IN_CNT_W  = cnt_width(LOG2_BYTES_IN);
  localparam int OUT_CNT_W = cnt_width(LOG2_BYTES_OUT);

  localparam logic [IN_CNT_W-1:0]   IN_LAST    = IN_CNT_W'(NB_IN - 1);
  localparam logic [OUT_CNT_W-1:0]  OUT_LAST   = OUT_CNT_W'(NB_OUT - 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_RELOAD = WAIT_CNT_W'(LATENCY - 1);

  seq_state_e              state_q, state_d;
  logic [IN_CNT_W-1:0]     in_cnt_q, in_cnt_d;
  logic [OUT_CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [WAIT_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [NB_IN*8-1:0]      operand_q;
  logic                    load_we;
  logic                    capture;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_LOAD;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // flush overrides every transition and suppresses both the load and the capture.
  always_comb begin
    state_d    = state_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    wait_cnt_d = wait_cnt_q;
    load_we    = 1'b0;
    capture    = 1'b0;
    if (flush) begin
      state_d    = ST_LOAD;
      in_cnt_d   = '0;
      out_cnt_d  = '0;
      wait_cnt_d = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (in_valid) begin
            load_we = 1'b1;
            if (in_cnt_q == IN_LAST) begin
              in_cnt_d = '0;
              state_d  = ST_ISSUE;
            end else begin
              in_cnt_d = in_cnt_q + IN_CNT_W'(1);
            end
          end
        end
        ST_ISSUE: begin
          wait_cnt_d = WAIT_RELOAD;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt_q == '0) begin
            capture = 1'b1;
            state_d = ST_UNLOAD;
          end else begin
            wait_cnt_d = wait_cnt_q - WAIT_CNT_W'(1);
          end
        end
        ST_UNLOAD: begin
          if (out_ready) begin
            if (out_cnt_q == OUT_LAST) begin
              out_cnt_d = '0;
              state_d   = ST_LOAD;
            end else begin
              out_cnt_d = out_cnt_q + OUT_CNT_W'(1);
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

  // Operand register stays put after ISSUE so the datapath may sample it any time in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      operand_q <= '0;
    end else begin
      for (int i = 0; i < NB_IN; i++) begin
        if (load_we && (in_cnt_q == IN_CNT_W'(i))) begin
          operand_q[i*8 +: 8] <= in_data;
        end
      end
    end
  end

  assign dp_operands = operand_q;
  assign in_ready    = (state_q == ST_LOAD);
  assign dp_start    = (state_q == ST_ISSUE);
  assign out_valid   = (state_q == ST_UNLOAD);
  assign busy        = (state_q != ST_LOAD);

  byte_unpacker #(
    .LOG2_BYTES (LOG2_BYTES_OUT)
  ) u_unpacker (
    .clk       (clk),
    .rst_n     (rst_n),
    .capture   (capture),
    .result_in (dp_result),
    .sel       (out_cnt_q),
    .enable    (out_valid),
    .byte_out  (out_data)
  );

endmodule

// File: tb/tb_operand_sequencer.sv
// Directed scoreboard bench for operand_sequencer with a fixed-latency datapath model.
module tb_operand_sequencer;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic [63:0] dp_operands;
  logic        dp_start;
  logic [31:0] dp_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int n_start_exp = 0;
  int n_start_seen = 0;

  logic [63:0] exp_ops[$];
  logic [7:0]  exp_bytes[$];
  logic [31:0] dp_value = 32'h0;
  logic [15:0] dly = 16'h0;

  // Datapath model: result is valid only LAT cycles after the dp_start cycle.
  assign dp_result = dly[LAT] ? dp_value : 32'h5A5A_5A5A;

  always #5 clk = ~clk;

  operand_sequencer #(
    .LOG2_BYTES_IN  (3),
    .LOG2_BYTES_OUT (2),
    .LATENCY        (LAT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .dp_operands (dp_operands),
    .dp_start    (dp_start),
    .dp_result   (dp_result),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s", name);
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_in_ready"},    64'(in_ready),  64'd1);
    check({tag, "_busy"},        64'(busy),      64'd0);
    check({tag, "_dp_start"},    64'(dp_start),  64'd0);
    check({tag, "_out_valid"},   64'(out_valid), 64'd0);
    check({tag, "_out_data"},    64'(out_data),  64'd0);
    check({tag, "_dp_operands"}, dp_operands,    64'd0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) fail("in_ready_timeout");
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hEE;
  endtask

  task automatic unload(input logic [15:0] pat, input int len);
    int k = 0;
    int t = 0;
    while (k < len) begin
      @(posedge clk); #2;
      if (out_valid) begin
        out_ready = pat[k];
        k++;
      end else begin
        out_ready = 1'b0;
        if (k > 0) begin
          fail("unload_early_exit");
          k = len;
        end else begin
          t++;
          if (t > 40) begin
            fail("unload_timeout");
            k = len;
          end
        end
      end
    end
    @(posedge clk); #2;
    out_ready = 1'b0;
    check("back_to_load_in_ready",  64'(in_ready),  64'd1);
    check("back_to_load_out_valid", 64'(out_valid), 64'd0);
  endtask

  task automatic txn(input logic [7:0] first, input logic [63:0] exp_word,
                     input logic [31:0] res, input logic [15:0] pat, input int plen,
                     input bit gap);
    exp_ops.push_back(exp_word);
    n_start_exp++;
    dp_value = res;
    for (int i = 0; i < 4; i++) exp_bytes.push_back(res[i*8 +: 8]);
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(first + 8'(i)));
      if (gap) begin
        @(posedge clk); #1;
      end
    end
    unload(pat, plen);
  endtask

  // Monitor: samples late in each cycle, well away from the rising edge.
  initial begin : monitor
    logic       prev_start = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         since = 0;
    forever begin
      @(posedge clk); #8;
      dly = {dly[14:0], dp_start};
      if (dp_start) begin
        n_start_seen++;
        since = 0;
        check("dp_start_width", 64'(prev_start), 64'd0);
        if (exp_ops.size() == 0) fail("unexpected_dp_start");
        else check("dp_operands", dp_operands, exp_ops.pop_front());
      end else begin
        since++;
      end
      if (busy) check("in_ready_while_busy", 64'(in_ready), 64'd0);
      if (dp_start || out_valid) check("busy_flag", 64'(busy), 64'd1);
      if (out_valid && !prev_valid) check("out_valid_latency", 64'(since), 64'(LAT + 1));
      if (prev_stall) check("stall_hold", {55'd0, out_valid, out_data}, {55'd0, 1'b1, prev_data});
      if (out_valid && out_ready) begin
        if (exp_bytes.size() == 0) fail("unexpected_out_byte");
        else check("out_data", 64'(out_data), 64'(exp_bytes.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_start = dp_start;
      prev_valid = out_valid;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    repeat (3) @(posedge clk);
    #1;
    idle_checks("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Back-to-back load, result streamed with out_ready held high.
    txn(8'h01, 64'h0807060504030201, 32'hDEADBEEF, 16'h000F, 4, 1'b0);

    // Consumer stalls: out_ready 1,0,0,1,1,1.
    txn(8'h11, 64'h1817161514131211, 32'h12345678, 16'b111001, 6, 1'b0);

    // Flush after five bytes; the byte offered with flush is dropped.
    for (int i = 0; i < 5; i++) send_byte(8'(8'hB0 + 8'(i)));
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h55;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_busy",     64'(busy),     64'd0);
    txn(8'hA0, 64'hA7A6A5A4A3A2A1A0, 32'hCAFEF00D, 16'h000F, 4, 1'b0);

    // Asynchronous reset in the middle of WAIT.
    exp_ops.push_back(64'h2827262524232221);
    n_start_exp++;
    dp_value = 32'h11111111;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h21 + 8'(i)));
    begin
      int t = 0;
      while (!dp_start && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
      if (!dp_start) fail("dp_start_timeout");
    end
    @(posedge clk); #3;
    check("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    idle_checks("async_reset");
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    txn(8'h31, 64'h3837363534333231, 32'h99887766, 16'h000F, 4, 1'b0);

    // Gapped in_valid: 1,0,1,0,... with junk on in_data in the gaps.
    txn(8'hC1, 64'hC8C7C6C5C4C3C2C1, 32'h0F1E2D3C, 16'h000F, 4, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("dp_start_count", 64'(n_start_seen), 64'(n_start_exp));
    check("ops_left",       64'(exp_ops.size()),   64'd0);
    check("bytes_left",     64'(exp_bytes.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_sequencer.md
# operand_sequencer

Byte-serial controller that sequences the shared 4-bit-lane test datapath (NAND / add / barrel-shift variants) in the Tiny Tapeout harness. It collects operand bytes from the 8-bit pin stream, fires the datapath once all operand bytes are present, and waits a fixed latency. It then captures the datapath result and streams the result bytes back out with a valid/ready handshake. It replaces the free-running select-addressed load/readout registers.

## Interface
- LOG2_BYTES_IN, 3: log2 of operand bytes; BYTES_IN = 1<<LOG2_BYTES_IN, minimum 1.
- LOG2_BYTES_OUT, 2: log2 of result bytes; BYTES_OUT = 1<<LOG2_BYTES_OUT, minimum 1.
- LATENCY, 1: datapath cycles from dp_start to valid dp_result, 1..15.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous abort, returns to LOAD.
- in_valid  in  1  in_data holds a byte.
- in_ready  out  1  sequencer accepts a byte this cycle.
- in_data  in  8  operand byte.
- dp_operands  out  BYTES_IN*8  registered operand word to the datapath.
- dp_start  out  1  one-cycle pulse; operands stable.
- dp_result  in  BYTES_OUT*8  datapath result.
- out_valid  out  1  out_data holds a result byte.
- out_ready  in  1  consumer takes the byte.
- out_data  out  8  result byte.
- busy  out  1  high in ISSUE, WAIT and UNLOAD.

## Operation
- States: LOAD, ISSUE, WAIT, UNLOAD.
- Reset values: state LOAD, in_cnt 0, out_cnt 0, wait_cnt 0, operand reg 0, result reg 0, dp_start 0, out_valid 0, busy 0. in_ready is 1 because it is decoded from the LOAD state.
- LOAD: in_ready=1. On in_valid, byte i = in_cnt is written to operand[i*8+7 -: 8] (byte 0 = LSB), and in_cnt increments. When the byte accepted has in_cnt = BYTES_IN-1, in_cnt wraps to 0 and the state goes to ISSUE.
- ISSUE: lasts exactly one cycle. dp_start=1, wait_cnt is loaded with LATENCY-1, then the state goes to WAIT.
- WAIT: wait_cnt decrements each cycle. In the cycle where wait_cnt = 0, dp_result is captured into the result reg and the state goes to UNLOAD.
- UNLOAD: out_valid=1 and out_data = result[out_cnt*8+7 -: 8]. On out_ready, out_cnt increments. When the byte taken has out_cnt = BYTES_OUT-1, out_cnt wraps to 0 and the state goes to LOAD.
- in_ready=0 outside LOAD. Input bytes offered in other states are not consumed.
- out_valid=0 outside UNLOAD. out_data is don't-care when out_valid=0 and is driven as 0.
- Stalls: in LOAD with in_valid=0, or in UNLOAD with out_ready=0, the state and counters hold. out_data stays stable while out_valid=1 and out_ready=0.
- flush: takes priority over all transitions. Next state is LOAD; in_cnt, out_cnt and wait_cnt go to 0; dp_start and out_valid go to 0. The operand reg and result reg are not cleared. A byte presented in the same cycle as flush is discarded.
- dp_operands is valid from ISSUE until the next LOAD write, so the datapath can sample it at any point during WAIT.
- Reset asserted mid-operation forces all reset values immediately (asynchronous). No partial transfer resumes after reset.

## Timing
- Handshake transfers occur on a rising edge with valid&&ready, for both in and out streams.
- Minimum transaction: BYTES_IN load cycles, 1 ISSUE, LATENCY WAIT, BYTES_OUT unload cycles. With defaults: 8+1+1+4 = 14 cycles.
- The edge that accepts the last operand byte enters ISSUE. dp_start is high in the following cycle.
- The result is captured on the edge LATENCY cycles after the ISSUE edge. out_valid is high in the next cycle.
- The edge that takes the last result byte enters LOAD. in_ready is high in the next cycle (no overlap of UNLOAD and LOAD).

## Structure
- Shared package holds:
  - the state enum (LOAD=0, ISSUE=1, WAIT=2, UNLOAD=3);
  - derived widths BYTES_IN and BYTES_OUT;
  - the wait-counter width of 4 bits.
- Sub-module byte_unpacker: a result-register and byte-select mux driving out_data. It is shared with any future readout path.
- Operand byte write-enable decode stays inline.

## Test plan
- Reset then 8 bytes 0x01..0x08 with in_valid held high. Expected: dp_operands = 0x0807060504030201, dp_start high exactly one cycle, in_ready=0 from ISSUE through UNLOAD.
- LATENCY=3, dp_result = 0xDEADBEEF. Expected: out_valid rises 4 cycles after dp_start, and bytes EF, BE, AD, DE come out in order with out_ready held high.
- out_ready toggled 1,0,0,1,1,1 during UNLOAD. Expected: out_data holds its value during the stall, no byte is skipped or duplicated, and the state returns to LOAD after the 4th accepted byte.
- flush after 5 bytes, followed by 8 bytes 0xA0..0xA7. Expected: in_cnt restarts, dp_operands = 0xA7A6A5A4A3A2A1A0, and a single dp_start.
- rst_n pulled low mid-WAIT. Expected: all outputs take reset values asynchronously, no capture occurs, and a full transaction succeeds after release.
- in_valid gapped as 1,0,1,0,... Expected: only the asserted cycles load bytes, and the final operand word matches the offered sequence.
